// File: rtl/lsq_ordered_buffer.sv
// In-order load/store queue: dispatch enqueue, operand capture, store commit, single-outstanding
// memory issue from the head, and a registered CDB broadcast for completed loads.
module lsq_ordered_buffer #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned IDX_W = 4,
   parameter int unsigned ROB_W = 5
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             clear_in,
   input  logic             disp_valid,
   input  logic             disp_is_store,
   input  logic [2:0]       disp_op,
   input  logic [ROB_W-1:0] disp_rob_id,
   output logic             full,
   input  logic             opnd_valid,
   input  logic [ROB_W-1:0] opnd_rob_id,
   input  logic [31:0]      opnd_addr,
   input  logic [31:0]      opnd_data,
   input  logic             commit_store,
   output logic             mem_req_valid,
   output logic             mem_req_wr,
   output logic [1:0]       mem_req_size,
   output logic [31:0]      mem_req_addr,
   output logic [31:0]      mem_req_data,
   input  logic             mem_busy,
   input  logic             mem_done,
   input  logic [31:0]      mem_rdata,
   output logic             cdb_valid,
   output logic [ROB_W-1:0] cdb_rob_id,
   output logic [31:0]      cdb_value
);

   typedef enum logic [1:0] {StWaitOpnd, StWaitCommit, StReady, StIssued} ent_st_e;

   function automatic logic [31:0] mask_data(input logic [2:0] op, input logic [31:0] d);
      logic [31:0] r;
      case (op[1:0])
         2'b00:   r = {24'b0, d[7:0]};
         2'b01:   r = {16'b0, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] d);
      logic [31:0] r;
      case (op)
         3'b000:  r = {{24{d[7]}}, d[7:0]};
         3'b001:  r = {{16{d[15]}}, d[15:0]};
         3'b100:  r = {24'b0, d[7:0]};
         3'b101:  r = {16'b0, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [IDX_W:0]   count_q, count_d;
   logic             inflight_q, inflight_d, drop_q, drop_d;
   logic             cdb_valid_q, cdb_valid_d;
   logic [ROB_W-1:0] cdb_rob_q, cdb_rob_d;
   logic [31:0]      cdb_value_q, cdb_value_d;

   logic [DEPTH-1:0] valid_q, valid_d;
   ent_st_e          st_q    [DEPTH];
   ent_st_e          st_d    [DEPTH];
   logic             store_q [DEPTH];
   logic             store_d [DEPTH];
   logic [2:0]       op_q    [DEPTH];
   logic [2:0]       op_d    [DEPTH];
   logic [ROB_W-1:0] rob_q   [DEPTH];
   logic [ROB_W-1:0] rob_d   [DEPTH];
   logic [31:0]      addr_q  [DEPTH];
   logic [31:0]      addr_d  [DEPTH];
   logic [31:0]      data_q  [DEPTH];
   logic [31:0]      data_d  [DEPTH];

   logic head_ready, pop, absorb, push;

   assign full       = (count_q == (IDX_W+1)'(DEPTH));
   assign head_ready = valid_q[head_q] && (st_q[head_q] == StReady);
   assign mem_req_valid = rdy_in && !rst_in && !clear_in && head_ready && !inflight_q && !mem_busy;
   assign pop    = inflight_q && mem_done && !drop_q;
   assign absorb = inflight_q && mem_done && drop_q;
   // A pop frees the head slot, so a full queue may still accept a same-cycle dispatch.
   assign push   = disp_valid && (!full || pop) && !clear_in;

   assign cdb_valid  = cdb_valid_q;
   assign cdb_rob_id = cdb_rob_q;
   assign cdb_value  = cdb_value_q;

   always_comb begin
      mem_req_wr   = 1'b0;
      mem_req_size = 2'b00;
      mem_req_addr = 32'b0;
      mem_req_data = 32'b0;
      if (mem_req_valid) begin
         mem_req_wr   = store_q[head_q];
         mem_req_size = (op_q[head_q][1:0] == 2'b10) ? 2'b11 : op_q[head_q][1:0];
         mem_req_addr = addr_q[head_q];
         mem_req_data = store_q[head_q] ? mask_data(op_q[head_q], data_q[head_q]) : 32'b0;
      end
   end

   always_comb begin : p_next
      logic [IDX_W-1:0] idx, start;
      logic [IDX_W:0]   run_len, rem;
      logic             run_open, keep, commit_pending;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      inflight_d  = inflight_q;
      drop_d      = drop_q;
      cdb_valid_d = 1'b0;
      cdb_rob_d   = cdb_rob_q;
      cdb_value_d = cdb_value_q;
      valid_d     = valid_q;
      st_d        = st_q;
      store_d     = store_q;
      op_d        = op_q;
      rob_d       = rob_q;
      addr_d      = addr_q;
      data_d      = data_q;
      idx            = '0;
      start          = '0;
      run_len        = '0;
      rem            = '0;
      run_open       = 1'b0;
      keep           = 1'b0;
      commit_pending = commit_store;

      if (clear_in) begin
         // Keep only the committed stores at the head; they are architecturally retired.
         start    = pop ? head_q + IDX_W'(1) : head_q;
         rem      = count_q - (IDX_W+1)'(pop);
         run_open = 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            idx  = start + IDX_W'(i);
            keep = run_open && ((IDX_W+1)'(i) < rem) && valid_q[idx] && store_q[idx] &&
                   ((st_q[idx] == StReady) || (st_q[idx] == StIssued));
            run_open     = keep;
            valid_d[idx] = keep;
            run_len      = run_len + (IDX_W+1)'(keep);
         end
         head_d     = start;
         tail_d     = start + run_len[IDX_W-1:0];
         count_d    = run_len;
         inflight_d = inflight_q && !pop && !absorb;
         if (absorb) begin
            drop_d = 1'b0;
         end else if (!pop && valid_q[head_q] && !store_q[head_q] && (st_q[head_q] == StIssued)) begin
            drop_d = 1'b1;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (opnd_valid && valid_q[i] && (st_q[i] == StWaitOpnd) && (rob_q[i] == opnd_rob_id)) begin
               addr_d[i] = opnd_addr;
               if (store_q[i]) begin
                  data_d[i] = mask_data(op_q[i], opnd_data);
                  st_d[i]   = StWaitCommit;
               end else begin
                  st_d[i] = StReady;
               end
            end
         end
         // Searching the post-operand state lets a same-cycle operand and commit meet.
         for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + IDX_W'(i);
            if (commit_pending && valid_q[idx] && store_q[idx] && (st_d[idx] == StWaitCommit)) begin
               st_d[idx]      = StReady;
               commit_pending = 1'b0;
            end
         end
         if (mem_req_valid) begin
            st_d[head_q] = StIssued;
            inflight_d   = 1'b1;
         end
         if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + IDX_W'(1);
            inflight_d      = 1'b0;
            if (!store_q[head_q]) begin
               cdb_valid_d = 1'b1;
               cdb_rob_d   = rob_q[head_q];
               cdb_value_d = extend(op_q[head_q], mem_rdata);
            end
         end
         if (absorb) begin
            inflight_d = 1'b0;
            drop_d     = 1'b0;
         end
         if (push) begin
            valid_d[tail_q] = 1'b1;
            st_d[tail_q]    = StWaitOpnd;
            store_d[tail_q] = disp_is_store;
            op_d[tail_q]    = disp_op;
            rob_d[tail_q]   = disp_rob_id;
            addr_d[tail_q]  = 32'b0;
            data_d[tail_q]  = 32'b0;
            tail_d          = tail_q + IDX_W'(1);
         end
         count_d = count_q + (IDX_W+1)'(push) - (IDX_W+1)'(pop);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         inflight_q  <= 1'b0;
         drop_q      <= 1'b0;
         cdb_valid_q <= 1'b0;
         cdb_rob_q   <= '0;
         cdb_value_q <= '0;
         valid_q     <= '0;
      end else if (rdy_in) begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         inflight_q  <= inflight_d;
         drop_q      <= drop_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_rob_q   <= cdb_rob_d;
         cdb_value_q <= cdb_value_d;
         valid_q     <= valid_d;
      end
   end

   // Payload is qualified by valid_q, so it needs no reset.
   always_ff @(posedge clk_in) begin
      if (rdy_in) begin
         st_q    <= st_d;
         store_q <= store_d;
         op_q    <= op_d;
         rob_q   <= rob_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_lsq_ordered_buffer.sv
// Directed bench for lsq_ordered_buffer: a scoreboard of expected memory requests and CDB results.
module tb_lsq_ordered_buffer;
   localparam int DEPTH = 16;
   localparam int IDX_W = 4;
   localparam int ROB_W = 5;

   logic             clk = 1'b0;
   logic             rst, rdy, clear, disp_valid, disp_is_store, opnd_valid, commit_store;
   logic [2:0]       disp_op;
   logic [ROB_W-1:0] disp_rob_id, opnd_rob_id;
   logic [31:0]      opnd_addr, opnd_data, mem_rdata;
   logic             mem_busy, mem_done;
   logic             full, mem_req_valid, mem_req_wr, cdb_valid;
   logic [1:0]       mem_req_size;
   logic [31:0]      mem_req_addr, mem_req_data, cdb_value;
   logic [ROB_W-1:0] cdb_rob_id;

   typedef struct {
      bit               wr;
      logic [1:0]       size;
      logic [31:0]      addr;
      logic [31:0]      data;
      logic [31:0]      rdata;
      bit               cdb;
      logic [ROB_W-1:0] rob;
      logic [31:0]      value;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   passed = 0;
   int   failed = 0;

   lsq_ordered_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .ROB_W(ROB_W)) dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clear),
      .disp_valid(disp_valid), .disp_is_store(disp_is_store), .disp_op(disp_op),
      .disp_rob_id(disp_rob_id), .full(full),
      .opnd_valid(opnd_valid), .opnd_rob_id(opnd_rob_id), .opnd_addr(opnd_addr),
      .opnd_data(opnd_data), .commit_store(commit_store),
      .mem_req_valid(mem_req_valid), .mem_req_wr(mem_req_wr), .mem_req_size(mem_req_size),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_busy(mem_busy),
      .mem_done(mem_done), .mem_rdata(mem_rdata),
      .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_disp(input logic st, input logic [2:0] op, input logic [ROB_W-1:0] tag);
      disp_valid = 1'b1; disp_is_store = st; disp_op = op; disp_rob_id = tag;
      tick();
      disp_valid = 1'b0;
   endtask

   task automatic do_opnd(input logic [ROB_W-1:0] tag, input logic [31:0] addr,
                          input logic [31:0] data, input bit with_commit);
      opnd_valid = 1'b1; opnd_rob_id = tag; opnd_addr = addr; opnd_data = data;
      commit_store = with_commit;
      tick();
      opnd_valid = 1'b0; commit_store = 1'b0;
   endtask

   task automatic exp_load(input logic [ROB_W-1:0] tag, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [31:0] value);
      exp_t e;
      e.wr = 1'b0; e.size = size; e.addr = addr; e.data = 32'h0; e.rdata = rdata;
      e.cdb = 1'b1; e.rob = tag; e.value = value;
      sb.push_back(e);
   endtask

   task automatic exp_store(input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] data);
      exp_t e;
      e.wr = 1'b1; e.size = size; e.addr = addr; e.data = data; e.rdata = 32'h0;
      e.cdb = 1'b0; e.rob = '0; e.value = 32'h0;
      sb.push_back(e);
   endtask

   // Let the next request issue, compare it, complete it and check the CDB pulse.
   task automatic serve(input bit push_en, input logic [ROB_W-1:0] push_tag);
      exp_t e;
      bit   found;
      if (sb.size() == 0) begin
         check("sb_nonempty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      mem_busy = 1'b0;
      #1;
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (mem_req_valid) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("req_seen", {31'b0, found}, 32'd1);
      if (!found) begin
         mem_busy = 1'b1;
         return;
      end
      check("req_wr", {31'b0, mem_req_wr}, {31'b0, e.wr});
      check("req_size", {30'b0, mem_req_size}, {30'b0, e.size});
      check("req_addr", mem_req_addr, e.addr);
      if (e.wr) check("req_data", mem_req_data, e.data);
      tick();
      mem_busy = 1'b1;
      mem_done = 1'b1; mem_rdata = e.rdata;
      if (push_en) begin
         disp_valid = 1'b1; disp_is_store = 1'b0; disp_op = 3'b010; disp_rob_id = push_tag;
      end
      tick();
      mem_done = 1'b0; disp_valid = 1'b0;
      #1;
      check("cdb_valid", {31'b0, cdb_valid}, {31'b0, e.cdb});
      if (e.cdb) begin
         check("cdb_rob", {27'b0, cdb_rob_id}, {27'b0, e.rob});
         check("cdb_value", cdb_value, e.value);
      end
      tick();
      check("cdb_pulse", {31'b0, cdb_valid}, 32'd0);
   endtask

   task automatic expect_idle(input string tag, input int cycles);
      mem_busy = 1'b0;
      #1;
      for (int c = 0; c < cycles; c++) begin
         check(tag, {31'b0, mem_req_valid}, 32'd0);
         tick();
      end
      mem_busy = 1'b1;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; clear = 1'b0; disp_valid = 1'b0; disp_is_store = 1'b0;
      disp_op = 3'b0; disp_rob_id = '0; opnd_valid = 1'b0; opnd_rob_id = '0;
      opnd_addr = 32'h0; opnd_data = 32'h0; commit_store = 1'b0;
      mem_busy = 1'b1; mem_done = 1'b0; mem_rdata = 32'h0;
      tick(); tick(); tick();
      rst = 1'b0;
      mem_busy = 1'b0;
      #1;
      check("rst_full", {31'b0, full}, 32'd0);
      check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
      check("rst_req_addr", mem_req_addr, 32'h0);
      check("rst_cdb_valid", {31'b0, cdb_valid}, 32'd0);
      check("rst_cdb_value", cdb_value, 32'h0);
      mem_busy = 1'b1;

      // Held while rdy is low: this dispatch must never appear.
      rdy = 1'b0;
      do_disp(1'b0, 3'b010, 5'd30);
      rdy = 1'b1;

      // LW
      do_disp(1'b0, 3'b010, 5'd3);
      exp_load(5'd3, 2'b11, 32'h100, 32'h0000_0080, 32'h0000_0080);
      do_opnd(5'd3, 32'h100, 32'h0, 1'b0);
      serve(1'b0, '0);

      // LB, LBU, LH, LHU
      do_disp(1'b0, 3'b000, 5'd4);
      do_disp(1'b0, 3'b100, 5'd6);
      do_disp(1'b0, 3'b001, 5'd9);
      do_disp(1'b0, 3'b101, 5'd10);
      exp_load(5'd4, 2'b00, 32'h104, 32'h0000_0080, 32'hFFFF_FF80);
      exp_load(5'd6, 2'b00, 32'h108, 32'h0000_0080, 32'h0000_0080);
      exp_load(5'd9, 2'b01, 32'h10C, 32'h0000_8001, 32'hFFFF_8001);
      exp_load(5'd10, 2'b01, 32'h110, 32'h0000_F234, 32'h0000_F234);
      do_opnd(5'd9, 32'h10C, 32'h0, 1'b0);
      do_opnd(5'd4, 32'h104, 32'h0, 1'b0);
      do_opnd(5'd10, 32'h110, 32'h0, 1'b0);
      do_opnd(5'd6, 32'h108, 32'h0, 1'b0);
      for (int k = 0; k < 4; k++) serve(1'b0, '0);

      // SW waits for commit
      do_disp(1'b1, 3'b010, 5'd5);
      do_opnd(5'd5, 32'h200, 32'hDEAD_BEEF, 1'b0);
      expect_idle("sw_no_commit", 10);
      commit_store = 1'b1;
      tick();
      commit_store = 1'b0;
      exp_store(2'b11, 32'h200, 32'hDEAD_BEEF);
      serve(1'b0, '0);

      // Fill, push+pop while full, then wrap head and tail
      for (int k = 0; k < DEPTH; k++) begin
         do_disp(1'b0, 3'b010, ROB_W'(k));
         do_opnd(ROB_W'(k), 32'h1000 + 32'(4 * k), 32'h0, 1'b0);
         exp_load(ROB_W'(k), 2'b11, 32'h1000 + 32'(4 * k), 32'h11 + 32'(k), 32'h11 + 32'(k));
      end
      check("fill_full", {31'b0, full}, 32'd1);
      do_disp(1'b0, 3'b010, 5'd20);
      check("full_ignore", {31'b0, full}, 32'd1);
      serve(1'b1, 5'd16);
      check("pushpop_full", {31'b0, full}, 32'd1);
      do_opnd(5'd16, 32'h2000, 32'h0, 1'b0);
      exp_load(5'd16, 2'b11, 32'h2000, 32'h7777, 32'h7777);
      serve(1'b0, '0);
      check("drain_not_full", {31'b0, full}, 32'd0);
      for (int k = 0; k < DEPTH - 1; k++) serve(1'b0, '0);
      expect_idle("wrap_empty", 2);

      // Clear keeps committed stores only
      do_disp(1'b1, 3'b000, 5'd1);
      do_opnd(5'd1, 32'h400, 32'h1234_5678, 1'b0);
      commit_store = 1'b1;
      tick();
      commit_store = 1'b0;
      do_disp(1'b1, 3'b010, 5'd2);
      do_opnd(5'd2, 32'h404, 32'hCAFE_F00D, 1'b1);
      do_disp(1'b0, 3'b010, 5'd3);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      exp_store(2'b00, 32'h400, 32'h0000_0078);
      exp_store(2'b11, 32'h404, 32'hCAFE_F00D);
      serve(1'b0, '0);
      serve(1'b0, '0);
      do_opnd(5'd3, 32'h408, 32'h0, 1'b0);
      expect_idle("clear_load_gone", 3);

      // Clear while a load is in flight drops its result
      do_disp(1'b0, 3'b010, 5'd7);
      do_opnd(5'd7, 32'h300, 32'h0, 1'b0);
      mem_busy = 1'b0;
      #1;
      check("drop_req_valid", {31'b0, mem_req_valid}, 32'd1);
      check("drop_req_addr", mem_req_addr, 32'h300);
      tick();
      mem_busy = 1'b1;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      mem_done = 1'b1; mem_rdata = 32'hABCD;
      tick();
      mem_done = 1'b0;
      #1;
      check("drop_no_cdb", {31'b0, cdb_valid}, 32'd0);
      tick();
      check("drop_no_cdb2", {31'b0, cdb_valid}, 32'd0);
      expect_idle("drop_empty", 2);
      do_disp(1'b0, 3'b100, 5'd8);
      exp_load(5'd8, 2'b00, 32'h310, 32'h0000_00F5, 32'h0000_00F5);
      do_opnd(5'd8, 32'h310, 32'h0, 1'b0);
      serve(1'b0, '0);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
